// File: rtl/reg_to_axi_lite.sv
// Regbus responder to AXI4-Lite initiator bridge, one transfer in flight.
// Request fields are captured in IDLE; the response is registered and shown for one cycle.
package reg_to_axi_lite_pkg;
    localparam int unsigned AddrWidth = 48;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef logic [1:0] axi_resp_t;
    localparam axi_resp_t RespOkay = 2'b00;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [DataWidth-1:0] wdata;
        logic [StrbWidth-1:0] wstrb;
        logic                 valid;
    } reg_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 error;
        logic                 ready;
    } reg_rsp_t;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [2:0]           prot;
    } axi_addr_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
    } axi_w_chan_t;

    typedef struct packed {
        axi_resp_t resp;
    } axi_b_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        axi_resp_t            resp;
    } axi_r_chan_t;

    typedef struct packed {
        axi_addr_chan_t aw;
        logic           aw_valid;
        axi_w_chan_t    w;
        logic           w_valid;
        logic           b_ready;
        axi_addr_chan_t ar;
        logic           ar_valid;
        logic           r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        axi_b_chan_t b;
        logic        b_valid;
        logic        ar_ready;
        axi_r_chan_t r;
        logic        r_valid;
    } axi_lite_rsp_t;
endpackage

// state          | meaning
// S_IDLE         | waiting for reg_req_i.valid, captures the request
// S_WR_ADDR_DATA | AW and W offered, each until its own handshake
// S_WR_RESP      | b_ready high, waiting for the write response
// S_RD_ADDR      | ar_valid high, waiting for ar_ready
// S_RD_DATA      | r_ready high, waiting for read data
// S_RESP         | reg_rsp_o.ready high for one cycle
module reg_to_axi_lite
    import reg_to_axi_lite_pkg::*;
#(
    parameter logic [2:0] AxiProt = 3'b000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  reg_req_t      reg_req_i,
    output reg_rsp_t      reg_rsp_o,
    output axi_lite_req_t axi_lite_req_o,
    input  axi_lite_rsp_t axi_lite_rsp_i,
    output logic          busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_RESP
    } state_t;

    state_t               r_state;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_wdata;
    logic [StrbWidth-1:0] r_wstrb;
    logic                 r_aw_valid;
    logic                 r_w_valid;
    logic                 r_aw_done;
    logic                 r_w_done;
    logic                 r_b_ready;
    logic                 r_ar_valid;
    logic                 r_r_ready;
    logic                 r_rsp_ready;
    logic                 r_rsp_error;
    logic [DataWidth-1:0] r_rsp_rdata;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_complete;
    logic w_w_complete;

    // Only the write-address/data handshakes feed the next-state decision directly.
    assign w_aw_hs       = r_aw_valid & axi_lite_rsp_i.aw_ready;
    assign w_w_hs        = r_w_valid & axi_lite_rsp_i.w_ready;
    assign w_aw_complete = r_aw_done | w_aw_hs;
    assign w_w_complete  = r_w_done | w_w_hs;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_aw_valid  <= 1'b0;
            r_w_valid   <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_b_ready   <= 1'b0;
            r_ar_valid  <= 1'b0;
            r_r_ready   <= 1'b0;
            r_rsp_ready <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (reg_req_i.valid) begin
                        r_addr  <= reg_req_i.addr;
                        r_wdata <= reg_req_i.wdata;
                        r_wstrb <= reg_req_i.wstrb;
                        if (reg_req_i.write) begin
                            r_state    <= S_WR_ADDR_DATA;
                            r_aw_valid <= 1'b1;
                            r_w_valid  <= 1'b1;
                        end else begin
                            r_state    <= S_RD_ADDR;
                            r_ar_valid <= 1'b1;
                        end
                    end
                end
                S_WR_ADDR_DATA: begin
                    if (w_aw_hs) begin
                        r_aw_valid <= 1'b0;
                        r_aw_done  <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_valid <= 1'b0;
                        r_w_done  <= 1'b1;
                    end
                    if (w_aw_complete && w_w_complete) begin
                        r_state   <= S_WR_RESP;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_b_ready <= 1'b1;
                    end
                end
                S_WR_RESP: begin
                    if (axi_lite_rsp_i.b_valid) begin
                        r_state     <= S_RESP;
                        r_b_ready   <= 1'b0;
                        r_rsp_ready <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_error <= (axi_lite_rsp_i.b.resp != RespOkay);
                    end
                end
                S_RD_ADDR: begin
                    if (axi_lite_rsp_i.ar_ready) begin
                        r_state    <= S_RD_DATA;
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (axi_lite_rsp_i.r_valid) begin
                        r_state     <= S_RESP;
                        r_r_ready   <= 1'b0;
                        r_rsp_ready <= 1'b1;
                        r_rsp_rdata <= axi_lite_rsp_i.r.data;
                        r_rsp_error <= (axi_lite_rsp_i.r.resp != RespOkay);
                    end
                end
                S_RESP: begin
                    // Clearing here keeps rdata/error at zero whenever ready is low.
                    r_state     <= S_IDLE;
                    r_rsp_ready <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_rsp_error <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        axi_lite_req_o          = '0;
        axi_lite_req_o.aw.addr  = r_addr;
        axi_lite_req_o.aw.prot  = AxiProt;
        axi_lite_req_o.aw_valid = r_aw_valid;
        axi_lite_req_o.w.data   = r_wdata;
        axi_lite_req_o.w.strb   = r_wstrb;
        axi_lite_req_o.w_valid  = r_w_valid;
        axi_lite_req_o.b_ready  = r_b_ready;
        axi_lite_req_o.ar.addr  = r_addr;
        axi_lite_req_o.ar.prot  = AxiProt;
        axi_lite_req_o.ar_valid = r_ar_valid;
        axi_lite_req_o.r_ready  = r_r_ready;
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = r_rsp_rdata;
        reg_rsp_o.error = r_rsp_error;
        reg_rsp_o.ready = r_rsp_ready;
    end

    assign busy_o = (r_state != S_IDLE);

endmodule

// File: tb/tb_reg_to_axi_lite.sv
// Bench for reg_to_axi_lite: reactive AXI-Lite slave with programmable stalls,
// regbus master driver and a word-memory reference model.
module tb_reg_to_axi_lite;
    import reg_to_axi_lite_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    reg_req_t      req;
    reg_rsp_t      rsp;
    axi_lite_req_t axi_req;
    axi_lite_rsp_t axi_rsp;
    logic          busy;

    always #5 clk_i = ~clk_i;

    reg_to_axi_lite dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .reg_req_i      (req),
        .reg_rsp_o      (rsp),
        .axi_lite_req_o (axi_req),
        .axi_lite_rsp_i (axi_rsp),
        .busy_o         (busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Environment rules: bit 12 of the address selects an erroring window,
    // unwritten words read back as a fixed function of their address.
    function automatic logic addr_err(input logic [47:0] a);
        return a[12];
    endfunction

    function automatic logic [31:0] init_word(input logic [47:0] a);
        return a[31:0] ^ 32'h5A5A_C3C3;
    endfunction

    // ---------------- AXI-Lite slave ----------------
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
    logic aw_got = 0, w_got = 0, ar_got = 0;
    logic p_aw_v = 0, p_w_v = 0, p_ar_v = 0;
    logic [47:0] p_aw_addr = '0, p_ar_addr = '0, obs_aw_addr = '0, obs_ar_addr = '0;
    logic [31:0] p_w_data = '0, obs_w_data = '0;
    logic [3:0]  p_w_strb = '0, obs_w_strb = '0;
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    int aw_vcyc = 0, w_vcyc = 0;
    int cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0, r_hs_cyc = 0;
    int stab_viol = 0, idle_viol = 0, prot_viol = 0;
    logic [31:0] slv_mem [logic [47:0]];

    task automatic slave_step();
        logic [31:0] word;
        cyc++;
        if (!rst_ni) begin
            axi_rsp = '0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; ar_hs_n = 0; r_hs_n = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            p_aw_v = 0; p_w_v = 0; p_ar_v = 0;
        end else begin
            if (p_aw_v && !aw_hs_n && (!axi_req.aw_valid || axi_req.aw.addr !== p_aw_addr)) stab_viol++;
            if (p_w_v && !w_hs_n && (!axi_req.w_valid || axi_req.w.data !== p_w_data ||
                                     axi_req.w.strb !== p_w_strb)) stab_viol++;
            if (p_ar_v && !ar_hs_n && (!axi_req.ar_valid || axi_req.ar.addr !== p_ar_addr)) stab_viol++;

            if (aw_hs_n) begin axi_rsp.aw_ready = 1'b0; aw_wait = 0; aw_got = 1'b1; end
            if (w_hs_n)  begin axi_rsp.w_ready  = 1'b0; w_wait  = 0; w_got  = 1'b1; end
            if (ar_hs_n) begin axi_rsp.ar_ready = 1'b0; ar_wait = 0; ar_got = 1'b1; end
            if (b_hs_n)  begin axi_rsp.b_valid  = 1'b0; b_wait  = 0; n_b++; end
            if (r_hs_n)  begin axi_rsp.r_valid  = 1'b0; r_wait  = 0; n_r++; end

            if (axi_req.aw_valid) aw_vcyc++;
            if (axi_req.w_valid)  w_vcyc++;
            if (axi_req.aw_valid && !axi_rsp.aw_ready) begin
                if (aw_wait >= aw_dly) axi_rsp.aw_ready = 1'b1; else aw_wait++;
            end
            if (axi_req.w_valid && !axi_rsp.w_ready) begin
                if (w_wait >= w_dly) axi_rsp.w_ready = 1'b1; else w_wait++;
            end
            if (axi_req.ar_valid && !axi_rsp.ar_ready) begin
                if (ar_wait >= ar_dly) axi_rsp.ar_ready = 1'b1; else ar_wait++;
            end

            if (aw_got && w_got && !axi_rsp.b_valid) begin
                if (b_wait >= b_dly) begin
                    axi_rsp.b_valid = 1'b1;
                    axi_rsp.b.resp  = addr_err(obs_aw_addr) ? 2'b10 : 2'b00;
                    if (!addr_err(obs_aw_addr)) begin
                        word = slv_mem.exists(obs_aw_addr) ? slv_mem[obs_aw_addr] : init_word(obs_aw_addr);
                        for (int i = 0; i < 4; i++)
                            if (obs_w_strb[i]) word[8*i +: 8] = obs_w_data[8*i +: 8];
                        slv_mem[obs_aw_addr] = word;
                    end
                    aw_got = 1'b0;
                    w_got  = 1'b0;
                end else b_wait++;
            end
            if (ar_got && !axi_rsp.r_valid) begin
                if (r_wait >= r_dly) begin
                    axi_rsp.r_valid = 1'b1;
                    if (addr_err(obs_ar_addr)) begin
                        axi_rsp.r.data = 32'hFFFF_FFFF;
                        axi_rsp.r.resp = 2'b11;
                    end else begin
                        axi_rsp.r.data = slv_mem.exists(obs_ar_addr) ? slv_mem[obs_ar_addr]
                                                                     : init_word(obs_ar_addr);
                        axi_rsp.r.resp = 2'b00;
                    end
                    ar_got = 1'b0;
                end else r_wait++;
            end

            aw_hs_n = axi_req.aw_valid && axi_rsp.aw_ready;
            w_hs_n  = axi_req.w_valid && axi_rsp.w_ready;
            ar_hs_n = axi_req.ar_valid && axi_rsp.ar_ready;
            b_hs_n  = axi_rsp.b_valid && axi_req.b_ready;
            r_hs_n  = axi_rsp.r_valid && axi_req.r_ready;
            if (aw_hs_n) begin n_aw++; obs_aw_addr = axi_req.aw.addr; aw_hs_cyc = cyc; end
            if (w_hs_n) begin
                n_w++; obs_w_data = axi_req.w.data; obs_w_strb = axi_req.w.strb; w_hs_cyc = cyc;
            end
            if (ar_hs_n) begin n_ar++; obs_ar_addr = axi_req.ar.addr; end
            if (r_hs_n) r_hs_cyc = cyc;

            p_aw_v = axi_req.aw_valid; p_aw_addr = axi_req.aw.addr;
            p_w_v  = axi_req.w_valid;  p_w_data = axi_req.w.data; p_w_strb = axi_req.w.strb;
            p_ar_v = axi_req.ar_valid; p_ar_addr = axi_req.ar.addr;

            if (!rsp.ready && (rsp.rdata != 0 || rsp.error)) idle_viol++;
            if ((axi_req.aw_valid && axi_req.aw.prot != 3'b000) ||
                (axi_req.ar_valid && axi_req.ar.prot != 3'b000)) prot_viol++;
        end
    endtask

    initial begin
        axi_rsp = '0;
        forever begin
            @(posedge clk_i);
            #1;
            slave_step();
        end
    end

    // ---------------- reference model and master ----------------
    logic [31:0] ref_mem [logic [47:0]];

    function automatic logic [31:0] ref_read(input logic [47:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic ref_write(input logic [47:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] word;
        word = ref_read(a);
        for (int i = 0; i < 4; i++)
            if (s[i]) word[8*i +: 8] = d[8*i +: 8];
        ref_mem[a] = word;
    endtask

    int req_cyc = 0, rdy_cyc = 0;

    task automatic xfer(input logic wr, input logic [47:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic scramble,
                        output logic [31:0] rd, output logic er);
        logic done;
        @(posedge clk_i);
        #2;
        n_aw = 0; n_w = 0; n_ar = 0; n_b = 0; n_r = 0; aw_vcyc = 0; w_vcyc = 0;
        req.addr = a; req.write = wr; req.wdata = wd; req.wstrb = ws; req.valid = 1'b1;
        req_cyc = cyc;
        done = 1'b0;
        rd = '0;
        er = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk_i);
            #2;
            if (rsp.ready) begin
                rd = rsp.rdata; er = rsp.error; rdy_cyc = cyc; done = 1'b1;
            end else if (scramble) begin
                req.addr  = {16'($urandom_range(0, 65535)), $urandom()};
                req.wdata = $urandom();
                req.wstrb = 4'($urandom_range(0, 15));
                req.write = 1'($urandom_range(0, 1));
            end
        end
        req.valid = 1'b0;
        check("xfer_done", done, 1'b1);
    endtask

    task automatic run_one(input logic wr, input logic [47:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input logic scramble);
        logic [31:0] rd, exp_rd;
        logic er, exp_er;
        xfer(wr, a, wd, ws, scramble, rd, er);
        exp_er = addr_err(a);
        if (wr) begin
            exp_rd = '0;
            if (!exp_er) ref_write(a, wd, ws);
        end else begin
            exp_rd = exp_er ? 32'hFFFF_FFFF : ref_read(a);
        end
        check("rdata", rd, exp_rd);
        check("error", er, exp_er);
        check("n_aw", n_aw, wr ? 1 : 0);
        check("n_w", n_w, wr ? 1 : 0);
        check("n_b", n_b, wr ? 1 : 0);
        check("n_ar", n_ar, wr ? 0 : 1);
        check("n_r", n_r, wr ? 0 : 1);
        if (wr) begin
            check("aw_addr", obs_aw_addr, a);
            check("w_data", obs_w_data, wd);
            check("w_strb", obs_w_strb, ws);
        end else begin
            check("ar_addr", obs_ar_addr, a);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0;
        rst_ni = 1'b0;
        ref_mem[48'h0000_0200_0020] = 32'h1234_5678;
        slv_mem[48'h0000_0200_0020] = 32'h1234_5678;
        repeat (3) @(posedge clk_i);
        #2;
        check("rst_rsp", {rsp.ready, rsp.error, rsp.rdata}, 0);
        check("rst_axi_ctl", {axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready,
                              axi_req.ar_valid, axi_req.r_ready}, 0);
        check("rst_busy", busy, 1'b0);
        rst_ni = 1'b1;

        // best-case write and read-back
        run_one(1'b1, 48'h0000_0200_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        check("wr_latency", rdy_cyc - req_cyc, 3);
        check("wr_aw_cycle", aw_hs_cyc - req_cyc, 1);
        check("wr_w_cycle", w_hs_cyc - req_cyc, 1);
        run_one(1'b0, 48'h0000_0200_0010, 32'h0, 4'h0, 1'b0);
        check("rd_latency", rdy_cyc - req_cyc, 3);

        // read with 5 wait cycles on R
        r_dly = 5;
        run_one(1'b0, 48'h0000_0200_0020, 32'h0, 4'h0, 1'b0);
        check("rd_r_to_ready", rdy_cyc - r_hs_cyc, 1);
        r_dly = 0;

        // split and reverse-split write channels
        aw_dly = 2;
        run_one(1'b1, 48'h0000_0200_0030, 32'hA5A5_0101, 4'hF, 1'b0);
        check("split_aw_vcyc", aw_vcyc, 3);
        check("split_w_vcyc", w_vcyc, 1);
        aw_dly = 0; w_dly = 2;
        run_one(1'b1, 48'h0000_0200_0034, 32'h0BAD_F00D, 4'h5, 1'b0);
        check("rsplit_aw_vcyc", aw_vcyc, 1);
        check("rsplit_w_vcyc", w_vcyc, 3);
        w_dly = 0;

        // error windows
        run_one(1'b1, 48'h0000_0200_1040, 32'h1111_2222, 4'hF, 1'b0);
        run_one(1'b0, 48'h0000_0200_1040, 32'h0, 4'h0, 1'b0);

        // asynchronous reset while stuck in RD_DATA
        r_dly = 1000;
        @(posedge clk_i);
        #2;
        req.addr = 48'h0000_0200_0004; req.write = 1'b0; req.valid = 1'b1;
        for (int i = 0; i < 20 && !axi_req.r_ready; i++) begin
            @(posedge clk_i);
            #2;
        end
        check("rst_reach_rd_data", axi_req.r_ready, 1'b1);
        #3;
        rst_ni = 1'b0;
        #1;
        check("arst_rsp", {rsp.ready, rsp.error, rsp.rdata}, 0);
        check("arst_axi_ctl", {axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready,
                               axi_req.ar_valid, axi_req.r_ready}, 0);
        check("arst_addr", axi_req.ar.addr, 0);
        check("arst_busy", busy, 1'b0);
        req.valid = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        r_dly = 0;
        run_one(1'b1, 48'h0000_0200_0008, 32'hCAFE_0008, 4'hF, 1'b0);
        run_one(1'b0, 48'h0000_0200_0008, 32'h0, 4'h0, 1'b0);

        // randomized back-to-back traffic with backpressure
        for (int t = 0; t < 40; t++) begin
            logic [47:0] a;
            logic e;
            aw_dly = $urandom_range(0, 4);
            w_dly  = $urandom_range(0, 4);
            b_dly  = $urandom_range(0, 4);
            ar_dly = $urandom_range(0, 4);
            r_dly  = $urandom_range(0, 4);
            e = ($urandom_range(0, 5) == 0);
            a = 48'h0001_0200_0000 | (48'(e) << 12) | (48'($urandom_range(0, 7)) << 2);
            run_one(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)), 1'b1);
        end

        check("stability_violations", stab_viol, 0);
        check("rsp_nonzero_outside_resp", idle_viol, 0);
        check("prot_violations", prot_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
